// File: rtl/exc_commit_unit.sv
// exc_commit_unit
//
// Registered exception/interrupt commit unit at the MEM/commit boundary.
// Arbitrates one interrupt source and fifteen synchronous exception flags for
// the instruction in MEM, latches the CP0 update values, then sequences a
// pipeline flush followed by a fetch redirect through a three-state FSM.
//
// Handshake: redirect_valid/redirect_pc form a valid/ready source. Once
// redirect_valid is high it stays high, with redirect_pc unchanged, until a
// cycle in which redirect_ready is also high; that cycle completes the
// transfer and the unit returns to IDLE on the next edge.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   ebase, status, cause  CP0 registers (sampled only in the hit cycle)
//   epc                   eret target
//   hw_int                asynchronous interrupt lines (synchronised here)
//   mem_*                 instruction in MEM: valid, pc, delay-slot flag,
//                         load/store flag, exception flags, fault address
//   accept                unit is IDLE and can take the MEM instruction
//   flush                 flush IF..MEM
//   redirect_valid/pc/ready  fetch redirect handshake
//   cp0_we, cp0_exccode, cp0_epc, cp0_bd      exception commit to CP0
//   cp0_badv_we, cp0_badvaddr                 BadVAddr update
//   cp0_eret              one-cycle eret pulse (clear EXL)
//   cp0_hw_ip             synchronised hw_int for Cause.IP
module exc_commit_unit #(
  parameter int HW_INT_W     = 6,
  parameter int SYNC_STAGES  = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         ebase,
  input  logic [31:0]         status,
  input  logic [31:0]         cause,
  input  logic [31:0]         epc,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic                mem_valid,
  input  logic [31:0]         mem_pc,
  input  logic                mem_in_ds,
  input  logic                mem_is_ls,
  input  logic [14:0]         mem_excvec,
  input  logic [31:0]         mem_badvaddr,
  output logic                accept,
  output logic                flush,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc,
  input  logic                redirect_ready,
  output logic                cp0_we,
  output logic [4:0]          cp0_exccode,
  output logic [31:0]         cp0_epc,
  output logic                cp0_bd,
  output logic                cp0_badv_we,
  output logic [31:0]         cp0_badvaddr,
  output logic                cp0_eret,
  output logic [HW_INT_W-1:0] cp0_hw_ip
);

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_MOD  = 5'h01;
  localparam logic [4:0] EXC_TLBL = 5'h02;
  localparam logic [4:0] EXC_TLBS = 5'h03;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;

  // ---------------------------------------------------------------------
  // Interrupt line synchroniser
  // ---------------------------------------------------------------------
  logic [HW_INT_W-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign cp0_hw_ip = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Event decode and priority
  // ---------------------------------------------------------------------
  logic [5:0] hw_ip_ext;
  logic [7:0] ip_all;
  logic       int_pending;
  logic       inst_adel;

  always_comb begin
    hw_ip_ext = '0;
    hw_ip_ext[HW_INT_W-1:0] = cp0_hw_ip;
  end

  assign ip_all      = {hw_ip_ext, cause[9:8]};
  // Interrupts are not taken on loads/stores so a partially performed
  // memory access is never restarted.
  assign int_pending = (|(ip_all & status[15:8])) & status[0] & ~status[1] & ~mem_is_ls;
  // A misaligned fetch PC is an instruction address error regardless of flag.
  assign inst_adel   = mem_excvec[0] | (mem_pc[1:0] != 2'b00);

  logic       ev_any;
  logic       ev_int;
  logic       ev_eret;
  logic       ev_refill;
  logic       ev_badv_pc;
  logic       ev_badv_data;
  logic [4:0] ev_code;

  always_comb begin
    ev_any       = 1'b1;
    ev_int       = 1'b0;
    ev_eret      = 1'b0;
    ev_refill    = 1'b0;
    ev_badv_pc   = 1'b0;
    ev_badv_data = 1'b0;
    ev_code      = EXC_INT;
    if (int_pending) begin
      ev_int = 1'b1;
    end else if (inst_adel) begin
      ev_code = EXC_ADEL; ev_badv_pc = 1'b1;
    end else if (mem_excvec[1]) begin
      ev_code = EXC_TLBL; ev_badv_pc = 1'b1; ev_refill = 1'b1;
    end else if (mem_excvec[2]) begin
      ev_code = EXC_TLBL; ev_badv_pc = 1'b1;
    end else if (mem_excvec[3]) begin
      ev_code = EXC_RI;
    end else if (mem_excvec[4]) begin
      ev_code = EXC_SYS;
    end else if (mem_excvec[5]) begin
      ev_code = EXC_BP;
    end else if (mem_excvec[6]) begin
      ev_code = EXC_OV;
    end else if (mem_excvec[7]) begin
      ev_code = EXC_TLBL; ev_badv_data = 1'b1; ev_refill = 1'b1;
    end else if (mem_excvec[8]) begin
      ev_code = EXC_TLBS; ev_badv_data = 1'b1; ev_refill = 1'b1;
    end else if (mem_excvec[9]) begin
      ev_code = EXC_TLBL; ev_badv_data = 1'b1;
    end else if (mem_excvec[10]) begin
      ev_code = EXC_TLBS; ev_badv_data = 1'b1;
    end else if (mem_excvec[11]) begin
      ev_code = EXC_MOD; ev_badv_data = 1'b1;
    end else if (mem_excvec[12]) begin
      ev_code = EXC_ADEL; ev_badv_data = 1'b1;
    end else if (mem_excvec[13]) begin
      ev_code = EXC_ADES; ev_badv_data = 1'b1;
    end else if (mem_excvec[14]) begin
      ev_eret = 1'b1;
    end else begin
      ev_any = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Vector address
  // ---------------------------------------------------------------------
  logic [31:0] vec_base;
  logic [31:0] vec_target;

  assign vec_base = status[22] ? 32'hBFC0_0200 : {ebase[31:12], 12'h000};

  always_comb begin
    vec_target = vec_base + 32'h0000_0180;
    if (ev_eret) begin
      vec_target = epc;
    end else if (ev_int && cause[23]) begin
      vec_target = vec_base + 32'h0000_0200;
    end else if (ev_refill && !status[1]) begin
      // Refill goes to the fast vector only outside a nested exception.
      vec_target = vec_base;
    end
  end

  logic hit;
  assign hit = (state_q == IDLE) & mem_valid & ev_any;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = REDIRECT;
        end else begin
          flush_cnt_d = flush_cnt_q + 3'd1;
        end
      end
      REDIRECT: begin
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded straight from the state register so an asynchronous reset drops
  // flush and redirect_valid immediately.
  assign accept         = (state_q == IDLE);
  assign flush          = (state_q == FLUSH);
  assign redirect_valid = (state_q == REDIRECT);

  // ---------------------------------------------------------------------
  // Latched commit values
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cp0_we       <= 1'b0;
      cp0_eret     <= 1'b0;
      cp0_badv_we  <= 1'b0;
      cp0_exccode  <= '0;
      cp0_epc      <= '0;
      cp0_bd       <= 1'b0;
      cp0_badvaddr <= '0;
      redirect_pc  <= '0;
    end else begin
      cp0_we      <= 1'b0;
      cp0_eret    <= 1'b0;
      cp0_badv_we <= 1'b0;
      if (hit) begin
        cp0_we      <= ~ev_eret;
        cp0_eret    <= ev_eret;
        redirect_pc <= vec_target;
        if (!ev_eret) begin
          cp0_exccode <= ev_code;
          cp0_epc     <= mem_in_ds ? (mem_pc - 32'd4) : mem_pc;
          cp0_bd      <= mem_in_ds;
          cp0_badv_we <= ev_badv_pc | ev_badv_data;
          if (ev_badv_pc)   cp0_badvaddr <= mem_pc;
          if (ev_badv_data) cp0_badvaddr <= mem_badvaddr;
        end
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{status[31:23], status[21:16], status[7:2],
                         cause[31:24], cause[22:10], cause[7:0], ebase[11:0]};

endmodule

// File: tb/tb_exc_commit_unit.sv
module tb_exc_commit_unit;

  localparam int HW_INT_W = 6;
  localparam int SYNC     = 2;
  localparam int FC       = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]         ebase, status, cause, epc;
  logic [HW_INT_W-1:0] hw_int;
  logic                mem_valid, mem_in_ds, mem_is_ls;
  logic [31:0]         mem_pc, mem_badvaddr;
  logic [14:0]         mem_excvec;
  logic                accept, flush, redirect_valid, redirect_ready;
  logic [31:0]         redirect_pc;
  logic                cp0_we, cp0_bd, cp0_badv_we, cp0_eret;
  logic [4:0]          cp0_exccode;
  logic [31:0]         cp0_epc, cp0_badvaddr;
  logic [HW_INT_W-1:0] cp0_hw_ip;

  exc_commit_unit #(.HW_INT_W(HW_INT_W), .SYNC_STAGES(SYNC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .ebase(ebase), .status(status), .cause(cause), .epc(epc),
    .hw_int(hw_int), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_in_ds(mem_in_ds),
    .mem_is_ls(mem_is_ls), .mem_excvec(mem_excvec), .mem_badvaddr(mem_badvaddr),
    .accept(accept), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .cp0_we(cp0_we),
    .cp0_exccode(cp0_exccode), .cp0_epc(cp0_epc), .cp0_bd(cp0_bd),
    .cp0_badv_we(cp0_badv_we), .cp0_badvaddr(cp0_badvaddr), .cp0_eret(cp0_eret),
    .cp0_hw_ip(cp0_hw_ip)
  );

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // Interrupt synchroniser seen as a plain delay line of sampled values.
  logic [HW_INT_W-1:0] hist_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q.delete();
      for (int i = 0; i < SYNC; i++) hist_q.push_back('0);
    end else begin
      hist_q.push_front(hw_int);
      while (hist_q.size() > SYNC) void'(hist_q.pop_back());
    end
  end

  function automatic logic [5:0] cur_ip();
    logic [5:0] r;
    r = '0;
    if (hist_q.size() >= SYNC) r[HW_INT_W-1:0] = hist_q[SYNC-1];
    return r;
  endfunction

  // ExcCode per mem_excvec bit; bit index order equals priority order.
  localparam logic [4:0] CODE_TBL [15] = '{5'h04, 5'h02, 5'h02, 5'h0A, 5'h08, 5'h09, 5'h0C,
                                          5'h02, 5'h03, 5'h02, 5'h03, 5'h01, 5'h04, 5'h05, 5'h00};

  typedef struct packed {
    logic        hit;
    logic        is_eret;
    logic [4:0]  code;
    logic        badv_we;
    logic [31:0] badv;
    logic [31:0] epc_v;
    logic        bd;
    logic [31:0] target;
  } exp_t;

  function automatic exp_t model(input logic [5:0] ip);
    exp_t        e;
    logic [14:0] f;
    logic [31:0] base;
    logic        intr;
    int          sel;
    e    = '0;
    intr = ((({ip, cause[9:8]}) & status[15:8]) != 8'h00) && status[0] && !status[1] && !mem_is_ls;
    f    = mem_excvec;
    if (mem_pc[1:0] != 2'b00) f[0] = 1'b1;
    sel = -1;
    if (intr) sel = 15;
    else for (int i = 0; i < 15; i++) if (f[i] && sel < 0) sel = i;
    e.hit   = mem_valid && (sel >= 0);
    base    = status[22] ? 32'hBFC00200 : {ebase[31:12], 12'h000};
    e.epc_v = mem_in_ds ? mem_pc - 32'd4 : mem_pc;
    e.bd    = mem_in_ds;
    if (sel == 15) begin
      e.code   = 5'h00;
      e.target = cause[23] ? base + 32'h200 : base + 32'h180;
    end else if (sel == 14) begin
      e.is_eret = 1'b1;
      e.target  = epc;
    end else if (sel >= 0) begin
      e.code = CODE_TBL[sel];
      if (sel <= 2) begin
        e.badv_we = 1'b1; e.badv = mem_pc;
      end else if (sel >= 7) begin
        e.badv_we = 1'b1; e.badv = mem_badvaddr;
      end
      if ((sel == 1 || sel == 7 || sel == 8) && !status[1]) e.target = base;
      else e.target = base + 32'h180;
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    ebase = '0; status = '0; cause = '0; epc = '0;
    mem_valid = 1'b0; mem_pc = '0; mem_in_ds = 1'b0; mem_is_ls = 1'b0;
    mem_excvec = '0; mem_badvaddr = '0;
  endtask

  // Anything on these inputs while the unit is busy must have no effect.
  task automatic scramble();
    ebase = $urandom; status = $urandom; cause = $urandom; epc = $urandom;
    mem_valid = 1'($urandom); mem_pc = $urandom; mem_in_ds = 1'($urandom);
    mem_is_ls = 1'($urandom); mem_excvec = 15'($urandom); mem_badvaddr = $urandom;
  endtask

  // Entered just after a negedge with the MEM/CP0 inputs already set.
  task automatic do_txn(input int ready_delay);
    exp_t e;
    e = model(cur_ip());
    check("accept_pre", accept, 1);
    check("hw_ip", cp0_hw_ip, cur_ip());
    redirect_ready = (ready_delay == 0);
    @(negedge clk);
    if (!e.hit) begin
      check("nohit_flush", flush, 0);
      check("nohit_we", cp0_we, 0);
      check("nohit_eret", cp0_eret, 0);
      check("nohit_accept", accept, 1);
      return;
    end
    check("t1_flush", flush, 1);
    check("t1_accept", accept, 0);
    check("t1_rv", redirect_valid, 0);
    check("t1_we", cp0_we, !e.is_eret);
    check("t1_eret", cp0_eret, e.is_eret);
    if (!e.is_eret) begin
      check("exccode", cp0_exccode, e.code);
      check("cp0_epc", cp0_epc, e.epc_v);
      check("cp0_bd", cp0_bd, e.bd);
      check("badv_we", cp0_badv_we, e.badv_we);
      if (e.badv_we) check("badvaddr", cp0_badvaddr, e.badv);
    end
    scramble();
    for (int k = 2; k <= FC; k++) begin
      @(negedge clk);
      check("flush_hold", flush, 1);
      check("we_once", cp0_we, 0);
      check("eret_once", cp0_eret, 0);
      check("rv_early", redirect_valid, 0);
      scramble();
    end
    @(negedge clk);
    check("rv_rise", redirect_valid, 1);
    check("flush_fall", flush, 0);
    check("rd_accept", accept, 0);
    check("redirect_pc", redirect_pc, e.target);
    for (int k = 1; k <= ready_delay; k++) begin
      scramble();
      @(negedge clk);
      check("rv_stall", redirect_valid, 1);
      check("pc_stall", redirect_pc, e.target);
      check("acc_stall", accept, 0);
      if (k == ready_delay) redirect_ready = 1'b1;
    end
    @(negedge clk);
    check("accept_back", accept, 1);
    check("rv_drop", redirect_valid, 0);
    redirect_ready = 1'b0;
    clear_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    int          got;
    clear_inputs();
    hw_int = '0;
    redirect_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_accept", accept, 1);
    check("rst_flush", flush, 0);
    check("rst_rv", redirect_valid, 0);
    check("rst_we", cp0_we, 0);
    check("rst_eret", cp0_eret, 0);
    check("rst_pc", redirect_pc, 0);
    check("rst_code", cp0_exccode, 0);
    check("rst_ip", cp0_hw_ip, 0);

    // ITLB refill, EBase vector, fast refill offset
    clear_inputs();
    ebase = 32'h80000000; mem_pc = 32'h80001000; mem_excvec = 15'h0002; mem_valid = 1'b1;
    do_txn(0);

    // Ov in a delay slot
    clear_inputs();
    ebase = 32'h80000000; mem_pc = 32'h80000104; mem_in_ds = 1'b1;
    mem_excvec = 15'h0040; mem_valid = 1'b1;
    do_txn(1);

    // RI + Sys + AdES together
    clear_inputs();
    ebase = 32'h80000000; mem_pc = 32'h80000300; mem_badvaddr = 32'h12345679;
    mem_excvec = 15'h2018; mem_valid = 1'b1;
    do_txn(0);

    // mem_valid=0 with flags set: no hit
    clear_inputs();
    mem_excvec = 15'h7FFF;
    do_txn(0);

    // Interrupt masked by mem_is_ls; also synchroniser latency
    clear_inputs();
    status = 32'h00400401; cause = 32'h00800000; mem_pc = 32'h80000200;
    mem_valid = 1'b1; mem_is_ls = 1'b1; hw_int = 6'b000001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ls_flush", flush, 0);
      check("ls_accept", accept, 1);
      check("sync_lat", cp0_hw_ip, (k == 0) ? 32'd0 : 32'd1);
    end
    hw_int = '0;
    mem_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Interrupt taken: hit in the cycle SYNC_STAGES after the line rises
    mem_is_ls = 1'b0; mem_valid = 1'b1; hw_int = 6'b000001;
    @(negedge clk);
    check("int_c1_flush", flush, 0);
    @(negedge clk);
    check("int_c2_flush", flush, 0);
    @(negedge clk);
    check("int_flush", flush, 1);
    check("int_we", cp0_we, 1);
    check("int_code", cp0_exccode, 0);
    check("int_badv_we", cp0_badv_we, 0);
    mem_valid = 1'b0; redirect_ready = 1'b1; status = 32'h0; cause = 32'h0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (redirect_valid) got = 1;
    end
    check("int_rv_seen", got, 1);
    check("int_pc", redirect_pc, 32'hBFC00400);
    @(negedge clk);
    check("int_accept", accept, 1);
    redirect_ready = 1'b0;
    hw_int = '0;
    clear_inputs();
    repeat (3) @(negedge clk);

    // eret with a stalled fetch stage
    clear_inputs();
    epc = 32'h80002000; mem_excvec = 15'h4000; mem_valid = 1'b1;
    do_txn(5);

    // Randomised transactions
    for (int n = 0; n < 30; n++) begin
      clear_inputs();
      if ($urandom_range(0, 2) == 0) hw_int = HW_INT_W'($urandom);
      status = $urandom; cause = $urandom; ebase = $urandom; epc = $urandom;
      mem_valid = ($urandom_range(0, 5) != 0);
      r = $urandom;
      mem_pc = ($urandom_range(0, 5) == 0) ? r : {r[31:2], 2'b00};
      mem_in_ds = 1'($urandom); mem_is_ls = 1'($urandom);
      mem_badvaddr = $urandom;
      case ($urandom_range(0, 3))
        0: mem_excvec = '0;
        1: mem_excvec = 15'(1 << $urandom_range(0, 14));
        2: mem_excvec = 15'($urandom);
        default: mem_excvec = 15'((1 << $urandom_range(0, 14)) | (1 << $urandom_range(0, 14)));
      endcase
      do_txn($urandom_range(0, 3));
    end
    hw_int = '0;

    // Reset in the second FLUSH cycle
    clear_inputs();
    mem_excvec = 15'h0010; mem_valid = 1'b1;
    @(negedge clk);
    check("rf_flush1", flush, 1);
    mem_valid = 1'b0; redirect_ready = 1'b1;
    @(negedge clk);
    check("rf_flush2", flush, 1);
    #2 rst = 1'b1;
    #1;
    check("rf_flush_async", flush, 0);
    check("rf_rv_async", redirect_valid, 0);
    check("rf_accept_async", accept, 1);
    check("rf_code_rst", cp0_exccode, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("rf_rv_never", redirect_valid, 0);
      check("rf_accept", accept, 1);
      check("rf_flush0", flush, 0);
      @(negedge clk);
    end
    check("rf_pc_rst", redirect_pc, 0);
    redirect_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exc_commit_unit.md
# exc_commit_unit

Parametrised, registered successor to the combinational exception prioritiser. It sits at the MEM/commit boundary and arbitrates interrupts and synchronous exceptions for the instruction in MEM, captures CP0 update data, and sequences pipeline flush and the fetch redirect through a small FSM. Asynchronous hardware interrupt lines are synchronised inside the block. The redirect to fetch uses a valid/ready handshake, so the unit copes with a stalled fetch stage.

## Interface
Parameters:
- HW_INT_W, 6, number of hardware interrupt lines (1..6); they map to IP[2+HW_INT_W-1:2]
- SYNC_STAGES, 2, flop stages on each hw_int line (2..4)
- FLUSH_CYCLES, 1, cycles `flush` stays asserted (1..7)

Ports (clock and reset first; reset is asynchronous and active-high):
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- ebase  in  32  CP0 EBase
- status  in  32  CP0 Status (BEV=22, IM=15:8, EXL=1, IE=0)
- cause  in  32  CP0 Cause (IV=23, software IP=9:8)
- epc  in  32  CP0 EPC, the eret target
- hw_int  in  HW_INT_W  asynchronous interrupt lines
- mem_valid  in  1  MEM instruction valid
- mem_pc  in  32  MEM instruction PC
- mem_in_ds  in  1  MEM instruction is in a branch delay slot
- mem_is_ls  in  1  MEM instruction is a load or store
- mem_excvec  in  15  exception flags, bit meanings listed under Operation
- mem_badvaddr  in  32  faulting data address
- accept  out  1  the unit can take the MEM instruction (state IDLE)
- flush  out  1  flush IF..MEM
- redirect_valid  out  1  redirect_pc is valid
- redirect_pc  out  32  handler address or eret target
- redirect_ready  in  1  fetch accepts the redirect
- cp0_we  out  1  one-cycle exception commit pulse
- cp0_exccode  out  5  ExcCode
- cp0_epc  out  32  value to write into EPC
- cp0_bd  out  1  value to write into Cause.BD
- cp0_badv_we  out  1  write BadVAddr
- cp0_badvaddr  out  32  value to write into BadVAddr
- cp0_eret  out  1  one-cycle eret pulse (clear EXL)
- cp0_hw_ip  out  HW_INT_W  synchronised hw_int, fed to Cause.IP

## Operation
- mem_excvec bit meanings: 0 inst AdEL, 1 ITLB refill, 2 ITLB invalid, 3 RI, 4 Sys, 5 Bp, 6 Ov, 7 DTLB refill load, 8 DTLB refill store, 9 DTLB invalid load, 10 DTLB invalid store, 11 Mod, 12 data AdEL, 13 AdES, 14 eret.
- Interrupt pending condition: ({zero-extended cp0_hw_ip, cause[9:8]} & status[15:8]) != 0, and IE=1, EXL=0, mem_is_ls=0.
- Priority, highest first: interrupt, inst AdEL (also taken when mem_pc[1:0]!=0), ITLB refill, ITLB invalid, RI, Sys, Bp, Ov, DTLB refill load, DTLB refill store, DTLB invalid load, DTLB invalid store, Mod, data AdEL, AdES, eret.
- ExcCode values: Int 0x00, Mod 0x01, TLBL 0x02, TLBS 0x03, AdEL 0x04, AdES 0x05, Sys 0x08, Bp 0x09, RI 0x0A, Ov 0x0C.
- Base address = BEV ? 0xBFC00200 : {ebase[31:12],12'h000}.
- Vector offsets:
  - TLB refill with EXL=0: base+0x000
  - interrupt with IV=1: base+0x200
  - all other exceptions: base+0x180
  - eret: redirect to epc
- cp0_epc = mem_in_ds ? mem_pc-4 : mem_pc (32-bit wrap); cp0_bd = mem_in_ds.
- BadVAddr:
  - for inst AdEL and ITLB events: cp0_badv_we=1, cp0_badvaddr=mem_pc
  - for DTLB, Mod, data AdEL and AdES: cp0_badv_we=1, cp0_badvaddr=mem_badvaddr
- FSM states IDLE, FLUSH, REDIRECT.
  - IDLE: a hit occurs when mem_valid and any event is present. On a hit, latch the outputs and go to FLUSH.
  - FLUSH: hold flush for FLUSH_CYCLES cycles, then go to REDIRECT.
  - REDIRECT: hold redirect_valid and redirect_pc steady until redirect_ready, then go to IDLE.
- While the state is not IDLE, accept=0 and MEM inputs are ignored.

## Timing
- Reset values: state IDLE; accept=1; all other outputs 0; sync flops 0.
- Interrupt latency: hw_int is visible on cp0_hw_ip SYNC_STAGES cycles after it is sampled.
- Hit in cycle T (IDLE): at T+1, flush=1 and cp0_we/cp0_eret pulse for exactly one cycle with the latched values. flush remains high through T+FLUSH_CYCLES.
- redirect_valid rises at T+FLUSH_CYCLES+1.
  - If redirect_ready is already high, the handshake completes in that cycle and the unit is back in IDLE (accept=1) at T+FLUSH_CYCLES+2.
  - redirect_pc must not change while redirect_valid=1 and redirect_ready=0.
- CP0 inputs (status, ebase, cause, epc) are sampled only in the hit cycle. Later changes to them do not alter the latched redirect_pc.
- mem_valid=0: no hit, even if mem_excvec is nonzero.
- Multiple flags set at once: only the highest-priority event is taken.
- rst asserted mid-sequence: immediate return to IDLE; flush and redirect_valid drop asynchronously; no redirect is completed.

## Test plan
- Reset, then ITLB refill with status=0x00000000, ebase=0x80000000, mem_pc=0x80001000 -> flush at T+1, cp0_exccode=0x02, cp0_badvaddr=0x80001000, redirect_pc=0x80000000.
- Delay slot: Ov with mem_in_ds=1, mem_pc=0x80000104 -> cp0_epc=0x80000100, cp0_bd=1, cp0_exccode=0x0C, redirect_pc=0x80000180.
- Priority: RI, Sys and AdES flags set together -> only RI is taken (0x0A); exactly one cp0_we pulse.
- Interrupt: status=0x00400401, cause[23]=1, hw_int[0] raised -> with SYNC_STAGES=2, the hit occurs 2 cycles later with redirect_pc=0xBFC00400. With mem_is_ls=1 the interrupt is not taken.
- Handshake: eret with epc=0x80002000, redirect_ready held low for 5 cycles -> redirect_valid and redirect_pc=0x80002000 stay stable, accept=0 throughout; accept=1 the cycle after ready.
- FLUSH_CYCLES=3; rst asserted in the second FLUSH cycle -> flush=0 at once, redirect_valid never asserts, accept=1 after reset.
